// File: rtl/joint_angle_ramp_if.sv
// Command/sample bundle for joint_angle_ramp: target triple in (valid/ready),
// ramped joint-angle samples out toward the kinematics stage.
interface joint_angle_ramp_if #(
  parameter int DATA_WIDTH_IN = 16
);
  logic                            i_cmd_valid;
  logic                            o_cmd_ready;
  logic signed [DATA_WIDTH_IN-1:0] i_tgt1;
  logic signed [DATA_WIDTH_IN-1:0] i_tgt2;
  logic signed [DATA_WIDTH_IN-1:0] i_tgt3;
  logic                            o_busy;
  logic                            o_thi_valid;
  logic signed [DATA_WIDTH_IN-1:0] o_thi1;
  logic signed [DATA_WIDTH_IN-1:0] o_thi2;
  logic signed [DATA_WIDTH_IN-1:0] o_thi3;

  modport master (
    output i_cmd_valid, i_tgt1, i_tgt2, i_tgt3,
    input  o_cmd_ready, o_busy, o_thi_valid, o_thi1, o_thi2, o_thi3
  );

  modport slave (
    input  i_cmd_valid, i_tgt1, i_tgt2, i_tgt3,
    output o_cmd_ready, o_busy, o_thi_valid, o_thi1, o_thi2, o_thi3
  );
endinterface

// File: rtl/joint_angle_ramp.sv
// Rate-limited ramp of three joint angles toward a commanded target, one sample per
// RATE_DIV cycles. Optional IDLE keep-alive samples: JOINT_RAMP_IDLE_REFRESH_EN.
module joint_angle_ramp #(
  parameter int DATA_WIDTH_IN = 16,
  parameter int STEP_MAX      = 64,
  parameter int RATE_DIV      = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  joint_angle_ramp_if.slave  bus
);

  localparam int W     = DATA_WIDTH_IN;
  localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(RATE_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
  localparam logic signed [W:0]   STEP_LIM = (W+1)'(STEP_MAX);
  localparam logic signed [W-1:0] STEP_W   = W'(STEP_MAX);
  localparam logic signed [W-1:0] ANG_ZERO = {W{1'b0}};

  typedef enum logic {ST_IDLE = 1'b0, ST_RAMP = 1'b1} state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic [DIV_W-1:0]      div_r;
  logic [DIV_W-1:0]      div_nxt_s;
  logic signed [W-1:0]   thi_r      [3];
  logic signed [W-1:0]   thi_nxt_s  [3];
  logic signed [W-1:0]   tgt_r      [3];
  logic signed [W-1:0]   tgt_nxt_s  [3];
  logic signed [W-1:0]   step_s     [3];
  logic                  valid_r;
  logic                  valid_nxt_s;
  logic                  cmd_ready_r;
  logic                  busy_r;
  logic                  tick_s;
  logic                  accept_s;
  logic                  done_s;

  // Difference is formed one bit wider than the angle, so extreme targets never wrap;
  // the stepped value always lies between cur and tgt and therefore stays representable.
  function automatic logic signed [W-1:0] step_toward(
    input logic signed [W-1:0] cur,
    input logic signed [W-1:0] tgt
  );
    logic signed [W:0] diff;
    diff = {tgt[W-1], tgt} - {cur[W-1], cur};
    if (diff > STEP_LIM) begin
      step_toward = cur + STEP_W;
    end else if (diff < -STEP_LIM) begin
      step_toward = cur - STEP_W;
    end else begin
      step_toward = tgt;
    end
  endfunction

  assign tick_s   = (div_r == DIV_LAST);
  assign accept_s = bus.i_cmd_valid & cmd_ready_r;

  // Per-joint candidate update and all-joints-arrived detection.
  always_comb begin
    done_s = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step_s[j] = step_toward(thi_r[j], tgt_r[j]);
      if (step_s[j] != tgt_r[j]) begin
        done_s = 1'b0;
      end else begin
        done_s = done_s;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: the sample that lands all joints on target ends the ramp.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_RAMP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (tick_s && done_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RAMP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values: divider, latched targets, angles, sample strobe.
  always_comb begin
    div_nxt_s   = div_r;
    valid_nxt_s = 1'b0;
    for (int j = 0; j < 3; j++) begin
      thi_nxt_s[j] = thi_r[j];
      tgt_nxt_s[j] = tgt_r[j];
    end
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          tgt_nxt_s[0] = bus.i_tgt1;
          tgt_nxt_s[1] = bus.i_tgt2;
          tgt_nxt_s[2] = bus.i_tgt3;
          div_nxt_s    = DIV_ZERO;
        end else begin
`ifdef JOINT_RAMP_IDLE_REFRESH_EN
          div_nxt_s   = tick_s ? DIV_ZERO : (div_r + DIV_ONE);
          valid_nxt_s = tick_s;
`else
          div_nxt_s   = DIV_ZERO;
`endif
        end
      end
      ST_RAMP: begin
        div_nxt_s = tick_s ? DIV_ZERO : (div_r + DIV_ONE);
        if (tick_s) begin
          for (int j = 0; j < 3; j++) begin
            thi_nxt_s[j] = step_s[j];
          end
          valid_nxt_s = 1'b1;
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      default: begin
        div_nxt_s   = DIV_ZERO;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered datapath and handshake outputs; ready/busy track the next state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      div_r       <= DIV_ZERO;
      valid_r     <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      for (int j = 0; j < 3; j++) begin
        thi_r[j] <= ANG_ZERO;
        tgt_r[j] <= ANG_ZERO;
      end
    end else begin
      div_r       <= div_nxt_s;
      valid_r     <= valid_nxt_s;
      cmd_ready_r <= (next_state_s == ST_IDLE);
      busy_r      <= (next_state_s == ST_RAMP);
      for (int j = 0; j < 3; j++) begin
        thi_r[j] <= thi_nxt_s[j];
        tgt_r[j] <= tgt_nxt_s[j];
      end
    end
  end

  assign bus.o_cmd_ready = cmd_ready_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_thi_valid = valid_r;
  assign bus.o_thi1      = thi_r[0];
  assign bus.o_thi2      = thi_r[1];
  assign bus.o_thi3      = thi_r[2];

endmodule

// File: tb/tb_joint_angle_ramp.sv
// Directed bench for joint_angle_ramp (RATE_DIV=4, STEP_MAX=64) with hand-computed expectations.
module tb_joint_angle_ramp;

  localparam int W = 16;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  joint_angle_ramp_if #(.DATA_WIDTH_IN(W)) bus ();

  joint_angle_ramp #(
    .DATA_WIDTH_IN(W),
    .STEP_MAX     (64),
    .RATE_DIV     (4)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs == exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    bus.i_cmd_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic send_cmd(input int t1, input int t2, input int t3, input bit hold);
    @(negedge i_clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_tgt1 = W'(t1);
    bus.i_tgt2 = W'(t2);
    bus.i_tgt3 = W'(t3);
    @(posedge i_clk);
    #1;
    if (!hold) bus.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_sample(output int lat);
    lat = 0;
    do begin
      @(posedge i_clk);
      #1;
      lat++;
    end while (!bus.o_thi_valid && lat < 40);
    chk("sample_seen", int'(bus.o_thi_valid), 1);
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge i_clk);
      #1;
      if (bus.o_thi_valid) n++;
    end
  endtask

  task automatic chk_angles(input string tag, input int a1, input int a2, input int a3);
    chk({tag, "_thi1"}, int'(bus.o_thi1), a1);
    chk({tag, "_thi2"}, int'(bus.o_thi2), a2);
    chk({tag, "_thi3"}, int'(bus.o_thi3), a3);
  endtask

  function automatic int idle_pulses(input int cycles);
`ifdef JOINT_RAMP_IDLE_REFRESH_EN
    return cycles / 4;
`else
    return 0;
`endif
  endfunction

  initial begin
    int lat;
    int np;
    int e1;
    int e2;
    int ns;
    bus.i_cmd_valid = 1'b0;
    bus.i_tgt1 = '0;
    bus.i_tgt2 = '0;
    bus.i_tgt3 = '0;

    // Reset state
    do_reset();
    #1;
    chk_angles("rst", 0, 0, 0);
    chk("rst_valid", int'(bus.o_thi_valid), 0);
    chk("rst_busy",  int'(bus.o_busy), 0);
    chk("rst_ready", int'(bus.o_cmd_ready), 1);

    // Idle after reset: keep-alive pulses only with the refresh build
    count_pulses(16, np);
    chk("idle_pulses", np, idle_pulses(16));

    // Two-sample ramp (100,-100,0)
    do_reset();
    send_cmd(100, -100, 0, 1'b0);
    chk("t1_ready_after_acc", int'(bus.o_cmd_ready), 0);
    chk("t1_busy_after_acc",  int'(bus.o_busy), 1);
    wait_sample(lat);
    chk("t1_lat1", lat, 4);
    chk_angles("t1_s1", 64, -64, 0);
    chk("t1_s1_busy", int'(bus.o_busy), 1);
    wait_sample(lat);
    chk("t1_lat2", lat, 4);
    chk_angles("t1_s2", 100, -100, 0);
    chk("t1_s2_ready", int'(bus.o_cmd_ready), 1);
    chk("t1_s2_busy",  int'(bus.o_busy), 0);
    count_pulses(12, np);
    chk("t1_no_more", np, idle_pulses(12));

    // Zero move: single sample equal to current
    do_reset();
    send_cmd(0, 0, 0, 1'b0);
    wait_sample(lat);
    chk("t2_lat", lat, 4);
    chk_angles("t2", 0, 0, 0);
    chk("t2_ready", int'(bus.o_cmd_ready), 1);
    count_pulses(8, np);
    chk("t2_no_more", np, idle_pulses(8));

    // Full-range ramp: no wrap, 512 samples
    do_reset();
    send_cmd(32767, -32768, 0, 1'b0);
    e1 = 0;
    e2 = 0;
    ns = 0;
    do begin
      wait_sample(lat);
      ns++;
      e1 = (32767 - e1 <= 64) ? 32767 : e1 + 64;
      e2 = (e2 + 32768 <= 64) ? -32768 : e2 - 64;
      chk("t3_lat", lat, 4);
      chk("t3_thi1", int'(bus.o_thi1), e1);
      chk("t3_thi2", int'(bus.o_thi2), e2);
    end while (!bus.o_cmd_ready && ns < 600);
    chk("t3_count", ns, 512);
    chk_angles("t3_final", 32767, -32768, 0);

    // Commands during a ramp are ignored; a held command is taken when ready returns
    do_reset();
    send_cmd(200, 0, 0, 1'b1);
    bus.i_tgt1 = -16'sd500;
    bus.i_tgt2 = 16'sd500;
    bus.i_tgt3 = 16'sd500;
    wait_sample(lat);
    chk_angles("t4_s1", 64, 0, 0);
    chk("t4_s1_ready", int'(bus.o_cmd_ready), 0);
    wait_sample(lat);
    chk_angles("t4_s2", 128, 0, 0);
    wait_sample(lat);
    chk_angles("t4_s3", 192, 0, 0);
    chk("t4_s3_ready", int'(bus.o_cmd_ready), 0);
    wait_sample(lat);
    chk_angles("t4_s4", 200, 0, 0);
    chk("t4_s4_ready", int'(bus.o_cmd_ready), 1);
    @(posedge i_clk);
    #1;
    bus.i_cmd_valid = 1'b0;
    chk("t4_acc2_ready", int'(bus.o_cmd_ready), 0);
    chk("t4_acc2_busy",  int'(bus.o_busy), 1);
    wait_sample(lat);
    chk("t4_acc2_lat", lat, 4);
    chk_angles("t4_acc2", 136, 64, 64);

    // Reset mid-ramp aborts at once
    do_reset();
    send_cmd(1000, 1000, 1000, 1'b0);
    wait_sample(lat);
    chk_angles("t5_s1", 64, 64, 64);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    #1;
    chk_angles("t5_rst", 0, 0, 0);
    chk("t5_valid", int'(bus.o_thi_valid), 0);
    chk("t5_busy",  int'(bus.o_busy), 0);
    chk("t5_ready", int'(bus.o_cmd_ready), 1);
    @(negedge i_clk);
    i_rst = 1'b1;
    count_pulses(20, np);
    chk("t5_no_pulses", np, idle_pulses(20));
    chk("t5_busy_after", int'(bus.o_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
